// File: rtl/pktctrl_pkg.sv
// Shared constants and FSM encoding for the MDIO capture-memory dump path.
package pktctrl_pkg;
  localparam int NUM_MEM = 96;
  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 9;
  localparam int SEL_W   = 7;
  localparam int CSUM_W  = 16;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_MEM - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    DONE
  } dump_state_e;
endpackage

// File: rtl/mdio_mem_dump_seq_if.sv
// Host control, memory-read request and dump-word handshake of the dump sequencer.
// master = sequencer side, slave = rf register block / memory-read mux side.
interface mdio_mem_dump_seq_if;
  import pktctrl_pkg::*;

  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  start_sel;
  logic [ADDR_W-1:0] start_addr;
  logic              rd_en;
  logic [SEL_W-1:0]  rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              data_vld;
  logic [DATA_W-1:0] data;
  logic              data_ack;
  logic              busy;
  logic              done;
  logic              err;
`ifdef MDIO_DUMP_CSUM_EN
  logic [CSUM_W-1:0] csum;
`endif

  modport master (
    input  start, abort, start_sel, start_addr, rd_data, data_ack,
    output rd_en, rd_sel, rd_addr, data_vld, data, busy, done, err
`ifdef MDIO_DUMP_CSUM_EN
    , output csum
`endif
  );

  modport slave (
    output start, abort, start_sel, start_addr, rd_data, data_ack,
    input  rd_en, rd_sel, rd_addr, data_vld, data, busy, done, err
`ifdef MDIO_DUMP_CSUM_EN
    , input csum
`endif
  );
endinterface

// File: rtl/mdio_dump_addr_cnt.sv
// Memory select / word address counter: load, +1 advance with select carry on address wrap.
// last flags the final word of the final memory; counter updates one cycle after load/adv.
module mdio_dump_addr_cnt
  import pktctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              adv,
  input  logic [SEL_W-1:0]  ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel  <= '0;
      addr <= '0;
    end else if (load) begin
      sel  <= ld_sel;
      addr <= ld_addr;
    end else if (adv) begin
      addr <= addr + 1'b1;
      if (&addr) sel <= sel + 1'b1;
    end
  end

  assign last = (sel == LAST_SEL) && (&addr);

endmodule

// File: rtl/mdio_mem_dump_seq.sv
// Walks capture memories word by word: one rd_en per word, word held on data_vld until data_ack
// (no advance while unacked); rd_en->data_vld = RD_LAT+1 cycles. Optional csum output: MDIO_DUMP_CSUM_EN.
module mdio_mem_dump_seq
  import pktctrl_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input logic                 clk,
  input logic                 rstn,
  mdio_mem_dump_seq_if.master bus
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  dump_state_e       state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              rd_en;
  logic              data_vld;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              err;
  logic              sel_ok;
  logic              start_ok;
  logic              cnt_adv;
  logic              last;
  logic [SEL_W-1:0]  cur_sel;
  logic [ADDR_W-1:0] cur_addr;
`ifdef MDIO_DUMP_CSUM_EN
  logic [CSUM_W-1:0] csum;
`endif

  assign sel_ok   = int'(bus.start_sel) < NUM_MEM;
  assign start_ok = bus.start && sel_ok && !bus.abort && (state == IDLE);
  // Counter moves only on an accepted word that is not the final one; abort blocks it.
  assign cnt_adv  = (state == HOLD) && bus.data_ack && !bus.abort && !last;

  mdio_dump_addr_cnt u_addr_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .load    (start_ok),
    .adv     (cnt_adv),
    .ld_sel  (bus.start_sel),
    .ld_addr (bus.start_addr),
    .sel     (cur_sel),
    .addr    (cur_addr),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      rd_en    <= 1'b0;
      data_vld <= 1'b0;
      data     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef MDIO_DUMP_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      rd_en <= 1'b0;
      if (bus.abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        data_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              done  <= 1'b0;
              err   <= 1'b0;
              busy  <= 1'b1;
              rd_en <= 1'b1;
              state <= ISSUE;
`ifdef MDIO_DUMP_CSUM_EN
              csum  <= '0;
`endif
            end else if (bus.start) begin
              err <= 1'b1;
            end
          end
          ISSUE: begin
            lat_cnt <= LAT_W'(RD_LAT);
            state   <= WAIT;
          end
          WAIT: begin
            lat_cnt <= lat_cnt - 1'b1;
            if (lat_cnt == LAT_W'(1)) begin
              data     <= bus.rd_data;
              data_vld <= 1'b1;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (bus.data_ack) begin
              data_vld <= 1'b0;
`ifdef MDIO_DUMP_CSUM_EN
              csum     <= csum + CSUM_W'(data);
`endif
              if (last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                rd_en <= 1'b1;
                state <= ISSUE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rd_en    = rd_en;
  assign bus.rd_sel   = cur_sel;
  assign bus.rd_addr  = cur_addr;
  assign bus.data_vld = data_vld;
  assign bus.data     = data;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
`ifdef MDIO_DUMP_CSUM_EN
  assign bus.csum     = csum;
`endif

endmodule

// File: tb/tb_mdio_mem_dump_seq.sv
// Bench for mdio_mem_dump_seq: directed scenarios plus random stimulus against a cycle-timed
// transaction model (rd_en at T -> word valid at T+RD_LAT+1; addr/sel walk with carry).
module tb_mdio_mem_dump_seq;
  import pktctrl_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int LAST_ADR = (1 << ADDR_W) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  mdio_mem_dump_seq_if bus ();
  mdio_mem_dump_seq #(.RD_LAT(RD_LAT)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input int sel, input int addr);
    int h;
    h = sel * 131 + addr * 29 + (addr >>> 6) * 7 + 5;
    return DATA_W'(h ^ (h >>> 9));
  endfunction

  // Memory with RD_LAT pipeline; unrelated cycles carry random junk
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.rd_en ? mem_word(int'(bus.rd_sel), int'(bus.rd_addr)) : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[RD_LAT-1];

  // Reference model: expected outputs for the current cycle
  logic              m_rd_en, m_vld, m_busy, m_done, m_err;
  logic [DATA_W-1:0] m_data;
  logic [15:0]       m_csum;
  int                m_sel, m_addr, issue_cyc, done_cyc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rd_en = 0; m_vld = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_data = '0; m_csum = '0; m_sel = 0; m_addr = 0;
      issue_cyc = -100; done_cyc = -100;
    end else begin
      if (bus.abort) begin
        m_busy = 0; m_vld = 0;
      end else if (!m_busy) begin
        if (bus.start && cyc != done_cyc) begin
          if (int'(bus.start_sel) < NUM_MEM) begin
            m_sel = int'(bus.start_sel); m_addr = int'(bus.start_addr);
            m_done = 0; m_err = 0; m_busy = 1; m_csum = '0; issue_cyc = cyc + 1;
          end else m_err = 1;
        end
      end else if (m_vld) begin
        if (bus.data_ack) begin
          m_vld  = 0;
          m_csum = m_csum + 16'(m_data);
          if (m_sel == NUM_MEM - 1 && m_addr == LAST_ADR) begin
            m_done = 1; m_busy = 0; done_cyc = cyc + 1;
          end else begin
            m_addr = m_addr + 1;
            if (m_addr > LAST_ADR) begin m_addr = 0; m_sel = m_sel + 1; end
            issue_cyc = cyc + 1;
          end
        end
      end else if (cyc + 1 == issue_cyc + RD_LAT + 1) begin
        m_vld = 1; m_data = mem_word(m_sel, m_addr);
      end
      m_rd_en = m_busy && (issue_cyc == cyc + 1);
      cyc = cyc + 1;
    end
  end

  // Per-cycle compare and event logs
  int rq_cyc[$], rq_sel[$], rq_addr[$], vq_cyc[$];
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rstn && cmp_en) begin
      check("rd_en", bus.rd_en, m_rd_en);
      if (m_rd_en) begin
        check("rd_sel", bus.rd_sel, m_sel);
        check("rd_addr", bus.rd_addr, m_addr);
      end
      check("data_vld", bus.data_vld, m_vld);
      if (m_vld) check("data", bus.data, m_data);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("err", bus.err, m_err);
`ifdef MDIO_DUMP_CSUM_EN
      check("csum", bus.csum, m_csum);
`endif
    end
    if (rstn && bus.rd_en) begin
      rq_cyc.push_back(cyc); rq_sel.push_back(int'(bus.rd_sel)); rq_addr.push_back(int'(bus.rd_addr));
    end
    if (rstn && bus.data_vld && !prev_vld) vq_cyc.push_back(cyc);
    prev_vld = bus.data_vld;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_cycles(input int n, input int ack_mode);
    for (int i = 0; i < n; i++) begin
      bus.data_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ack_mode);
      tick();
    end
  endtask

  task automatic do_start(input int sel, input int addr);
    bus.start = 1'b1; bus.start_sel = SEL_W'(sel); bus.start_addr = ADDR_W'(addr);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic clear_logs();
    rq_cyc.delete(); rq_sel.delete(); rq_addr.delete(); vq_cyc.delete();
  endtask

  logic [DATA_W-1:0] held;
  int k;

  initial begin
    bus.start = 0; bus.abort = 0; bus.start_sel = '0; bus.start_addr = '0; bus.data_ack = 0;
    #1 rstn = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", bus.rd_en, 0);    check("rst_rd_sel", bus.rd_sel, 0);
    check("rst_rd_addr", bus.rd_addr, 0); check("rst_vld", bus.data_vld, 0);
    check("rst_data", bus.data, 0);      check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);      check("rst_err", bus.err, 0);
    rstn = 1'b1; cmp_en = 1'b1;
    tick();

    // Immediate ack
    clear_logs(); bus.data_ack = 1;
    do_start(0, 0);
    run_cycles(14, 1);
    check("t1_nreq", rq_cyc.size() >= 3, 1);
    check("t1_addr0", rq_addr[0], 0); check("t1_addr1", rq_addr[1], 1); check("t1_addr2", rq_addr[2], 2);
    check("t1_sel0", rq_sel[0], 0);
    check("t1_period", rq_cyc[1] - rq_cyc[0], 4);
    check("t1_period2", rq_cyc[2] - rq_cyc[1], 4);
    check("t1_vld_lat", vq_cyc[0] - rq_cyc[0], 3);
    do_abort();

    // Address wrap into next memory
    clear_logs();
    do_start(5, 'h7FFE);
    k = 0;
    while (rq_cyc.size() < 3 && k < 200) begin run_cycles(1, 2); k++; end
    check("t2_nreq", rq_cyc.size() >= 3, 1);
    check("t2_sel0", rq_sel[0], 5); check("t2_addr0", rq_addr[0], 'h7FFE);
    check("t2_sel1", rq_sel[1], 5); check("t2_addr1", rq_addr[1], 'h7FFF);
    check("t2_sel2", rq_sel[2], 6); check("t2_addr2", rq_addr[2], 0);
    do_abort();

    // Last word of last memory
    clear_logs();
    do_start(95, 'h7FFF);
    k = 0;
    while (!bus.done && k < 50) begin run_cycles(1, 1); k++; end
    check("t3_done", bus.done, 1); check("t3_busy", bus.busy, 0);
    run_cycles(10, 1);
    check("t3_nreq", rq_cyc.size(), 1);
    check("t3_done_sticky", bus.done, 1);
`ifdef MDIO_DUMP_CSUM_EN
    check("t3_csum", bus.csum, 16'(mem_word(95, 'h7FFF)));
`endif

    // Backpressure then abort with simultaneous ack
    clear_logs();
    do_start(10, 100);
    k = 0;
    while (!bus.data_vld && k < 20) begin run_cycles(1, 0); k++; end
    held = bus.data;
    check("t4_held_word", held, mem_word(10, 100));
    run_cycles(50, 0);
    check("t4_data_stable", bus.data, held); check("t4_vld", bus.data_vld, 1);
    check("t4_nreq", rq_cyc.size(), 1);
    bus.abort = 1; bus.data_ack = 1; tick(); bus.abort = 0; bus.data_ack = 0;
    check("t4_vld_off", bus.data_vld, 0); check("t4_busy", bus.busy, 0);
    check("t4_done", bus.done, 0);
    check("t4_no_adv_addr", bus.rd_addr, 100); check("t4_no_adv_sel", bus.rd_sel, 10);
    run_cycles(5, 1);
    check("t4_nreq_after", rq_cyc.size(), 1);

    // Bad start, valid start, start while busy
    clear_logs();
    do_start(96, 0);
    check("t5_err", bus.err, 1);
    run_cycles(10, 2);
    check("t5_nreq", rq_cyc.size(), 0); check("t5_busy", bus.busy, 0);
    do_start(1, 3);
    check("t5_err_clr", bus.err, 0); check("t5_busy_on", bus.busy, 1);
    do_start(2, 7);
    k = 0;
    while (rq_cyc.size() < 2 && k < 200) begin run_cycles(1, 2); k++; end
    check("t5_sel0", rq_sel[0], 1); check("t5_addr0", rq_addr[0], 3);
    check("t5_sel1", rq_sel[1], 1); check("t5_addr1", rq_addr[1], 4);
    check("t5_err_busy", bus.err, 0);
    do_abort();

    // Reset during WAIT
    do_start(3, 3);
    tick();
    rstn = 1'b0; #1;
    check("t6_rd_en", bus.rd_en, 0);    check("t6_rd_sel", bus.rd_sel, 0);
    check("t6_rd_addr", bus.rd_addr, 0); check("t6_vld", bus.data_vld, 0);
    check("t6_data", bus.data, 0);      check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);      check("t6_err", bus.err, 0);
    tick(); rstn = 1'b1;
    clear_logs();
    run_cycles(10, 2);
    check("t6_nreq", rq_cyc.size(), 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.abort = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: begin bus.start_sel = SEL_W'(95); bus.start_addr = ADDR_W'($urandom_range(LAST_ADR - 6, LAST_ADR)); end
        1: begin bus.start_sel = SEL_W'($urandom_range(0, 99)); bus.start_addr = ADDR_W'($urandom_range(LAST_ADR - 3, LAST_ADR)); end
        default: begin bus.start_sel = SEL_W'($urandom_range(0, 99)); bus.start_addr = ADDR_W'($urandom); end
      endcase
      bus.data_ack = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.start = 0; bus.abort = 0; bus.data_ack = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
